// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch and data access.
// Serializes requests, holds the memory-side signals until ack, and aborts stuck accesses with a watchdog.
module mem_port_arbiter #(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,

    output logic        bus_err,
    output logic        stall,
    output logic [1:0]  dbg_state
);

    // Handshake: a requester raises x_req and holds it (with stable address/data)
    // until it sees the one-cycle x_ready pulse; the memory side keeps mem_req and
    // its payload stable until mem_ack is sampled high on a rising edge.

    localparam int          CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit          WDOG_EN  = (TIMEOUT != 0);
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_e;

    state_e        state_q;
    logic          last_grant_q;
    logic [CW-1:0] cnt_q;
    logic          mem_req_q;
    logic          mem_we_q;
    logic [31:0]   mem_addr_q;
    logic [31:0]   mem_wdata_q;
    logic [31:0]   if_rdata_q;
    logic [31:0]   d_rdata_q;
    logic          if_ready_q;
    logic          d_ready_q;
    logic          bus_err_q;

    logic if_elig;
    logic d_elig;
    logic grant_d;
    logic timeout_hit;

    // A requester is masked in its own ready cycle so a held request is not re-served.
    assign if_elig     = if_req & ~if_ready_q;
    assign d_elig      = d_req & ~d_ready_q;
    assign grant_d     = d_elig & (~if_elig | ~last_grant_q);
    assign timeout_hit = WDOG_EN && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            if_ready_q   <= 1'b0;
            d_ready_q    <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        mem_req_q    <= 1'b1;
                        mem_we_q     <= d_we;
                        mem_addr_q   <= d_addr;
                        mem_wdata_q  <= d_wdata;
                        last_grant_q <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= BUSY_D;
                    end else if (if_elig) begin
                        mem_req_q    <= 1'b1;
                        mem_we_q     <= 1'b0;
                        mem_addr_q   <= if_addr;
                        mem_wdata_q  <= '0;
                        last_grant_q <= 1'b0;
                        cnt_q        <= '0;
                        state_q      <= BUSY_I;
                    end
                end
                BUSY_I: begin
                    if (mem_ack) begin
                        if_rdata_q <= mem_rdata;
                        if_ready_q <= 1'b1;
                        mem_req_q  <= 1'b0;
                        state_q    <= IDLE;
                    end else if (timeout_hit) begin
                        if_rdata_q <= ERR_DATA;
                        if_ready_q <= 1'b1;
                        bus_err_q  <= 1'b1;
                        mem_req_q  <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                BUSY_D: begin
                    // Stores complete without touching d_rdata, even on abort.
                    if (mem_ack) begin
                        if (!mem_we_q) d_rdata_q <= mem_rdata;
                        d_ready_q <= 1'b1;
                        mem_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end else if (timeout_hit) begin
                        if (!mem_we_q) d_rdata_q <= ERR_DATA;
                        d_ready_q <= 1'b1;
                        bus_err_q <= 1'b1;
                        mem_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    mem_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_ready  = if_ready_q;
    assign d_rdata   = d_rdata_q;
    assign d_ready   = d_ready_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign bus_err   = bus_err_q;
    assign dbg_state = state_q;

    assign stall = (if_req & ~if_ready_q) | (d_req & ~d_ready_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 4-cycle watchdog.
// Each task drives one scenario and checks outputs 1-2 time units after the rising edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        bus_err;
    logic        stall;
    logic [1:0]  dbg_state;

    int vectors = 0;
    int errors  = 0;
    logic [31:0] exp_d_rdata;

    mem_port_arbiter #(.TIMEOUT(4), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .bus_err(bus_err), .stall(stall), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        exp_d_rdata = '0;
    endtask

    task automatic test_reset();
        apply_reset();
        reset = 1'b1;
        #1;
        vectors++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b exp 0", mem_req); end
        vectors++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b exp 0", mem_we); end
        vectors++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h exp 0", mem_addr); end
        vectors++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h exp 0", mem_wdata); end
        vectors++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h exp 0/0", if_rdata, d_rdata); end
        vectors++; if ({if_ready, d_ready, bus_err} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b exp 000", {if_ready, d_ready, bus_err}); end
        vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b exp 0", stall); end
        vectors++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        apply_reset();
        if_req = 1'b1; if_addr = 32'h100;
        #1;
        vectors++; if (stall !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL fetch_c0: stall %b mem_req %b exp 1 0", stall, mem_req); end
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h2002_0005;
        #1;
        vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin errors++; $display("FAIL fetch_c1: req %b addr %h we %b exp 1 100 0", mem_req, mem_addr, mem_we); end
        vectors++; if (stall !== 1'b1) begin errors++; $display("FAIL fetch_c1_stall: got %b exp 1", stall); end
        tick();
        mem_ack = 1'b0;
        #1;
        vectors++; if (if_ready !== 1'b1 || if_rdata !== 32'h2002_0005) begin errors++; $display("FAIL fetch_c2: ready %b rdata %h exp 1 20020005", if_ready, if_rdata); end
        vectors++; if (stall !== 1'b0 || mem_req !== 1'b0 || bus_err !== 1'b0) begin errors++; $display("FAIL fetch_c2_misc: stall %b req %b err %b exp 0 0 0", stall, mem_req, bus_err); end
        if_req = 1'b0;
        tick();
        #1;
        vectors++; if (if_ready !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL fetch_c3: ready %b req %b exp 0 0", if_ready, mem_req); end
        // ack while idle must be ignored
        mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        tick();
        mem_ack = 1'b0;
        #1;
        vectors++; if (if_ready !== 1'b0 || d_ready !== 1'b0 || if_rdata !== 32'h2002_0005) begin errors++; $display("FAIL idle_ack: ready %b/%b rdata %h exp 0/0 20020005", if_ready, d_ready, if_rdata); end
    endtask

    task automatic test_store();
        apply_reset();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hCAFE_F00D;
        tick();
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) begin mem_ack = 1'b1; mem_rdata = 32'h1234_5678; end
            #1;
            vectors++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL store_c%0d: req %b we %b addr %h wdata %h", c, mem_req, mem_we, mem_addr, mem_wdata); end
            vectors++; if (d_ready !== 1'b0) begin errors++; $display("FAIL store_early_ready_c%0d: got %b exp 0", c, d_ready); end
            tick();
        end
        mem_ack = 1'b0;
        #1;
        vectors++; if (d_ready !== 1'b1 || bus_err !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL store_done: ready %b err %b req %b exp 1 0 0", d_ready, bus_err, mem_req); end
        vectors++; if (d_rdata !== exp_d_rdata) begin errors++; $display("FAIL store_rdata: got %h exp %h", d_rdata, exp_d_rdata); end
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        reset = 1'b1;
        idle_inputs();
        if_req = 1'b1; if_addr = 32'h1000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
        tick();
        reset = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            exp_addr = (j % 2 == 0) ? 32'h1000 : 32'h2000;
            exp_data = 32'hA000_0000 | 32'(j);
            mem_ack = 1'b1; mem_rdata = exp_data;
            #1;
            vectors++; if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin errors++; $display("FAIL b2b_grant%0d: req %b addr %h exp 1 %h", j, mem_req, mem_addr, exp_addr); end
            tick();
            mem_ack = 1'b0;
            #1;
            if (j % 2 == 0) begin
                vectors++; if (if_ready !== 1'b1 || d_ready !== 1'b0 || if_rdata !== exp_data) begin errors++; $display("FAIL b2b_done%0d: ifr %b dr %b rdata %h exp 1 0 %h", j, if_ready, d_ready, if_rdata, exp_data); end
            end else begin
                vectors++; if (d_ready !== 1'b1 || if_ready !== 1'b0 || d_rdata !== exp_data) begin errors++; $display("FAIL b2b_done%0d: dr %b ifr %b rdata %h exp 1 0 %h", j, d_ready, if_ready, d_rdata, exp_data); end
            end
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        tick();
        for (int c = 1; c <= 4; c++) begin
            #1;
            vectors++; if (mem_req !== 1'b1 || d_ready !== 1'b0 || bus_err !== 1'b0) begin errors++; $display("FAIL timeout_wait_c%0d: req %b ready %b err %b exp 1 0 0", c, mem_req, d_ready, bus_err); end
            tick();
        end
        d_req = 1'b0;
        if_req = 1'b1; if_addr = 32'h200;
        #1;
        vectors++; if (d_ready !== 1'b1 || bus_err !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL timeout_abort: ready %b err %b req %b exp 1 1 0", d_ready, bus_err, mem_req); end
        vectors++; if (d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL timeout_rdata: got %h exp deadbeef", d_rdata); end
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        #1;
        vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h200 || bus_err !== 1'b0) begin errors++; $display("FAIL after_to_grant: req %b addr %h err %b exp 1 200 0", mem_req, mem_addr, bus_err); end
        tick();
        mem_ack = 1'b0;
        #1;
        vectors++; if (if_ready !== 1'b1 || if_rdata !== 32'h1111_2222 || bus_err !== 1'b0) begin errors++; $display("FAIL after_to_done: ready %b rdata %h err %b exp 1 11112222 0", if_ready, if_rdata, bus_err); end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        tick();
        if_req = 1'b1; if_addr = 32'h600;
        tick();
        #1;
        vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin errors++; $display("FAIL rmid_busy: req %b addr %h exp 1 300", mem_req, mem_addr); end
        reset = 1'b1;
        #1;
        vectors++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rmid_drop: req %b exp 0", mem_req); end
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h9999_0000;
        #1;
        vectors++; if (d_ready !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL rmid_held: ready %b req %b exp 0 0", d_ready, mem_req); end
        mem_ack = 1'b0;
        reset = 1'b0;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        #1;
        vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h600 || mem_we !== 1'b0) begin errors++; $display("FAIL rmid_first: req %b addr %h we %b exp 1 600 0", mem_req, mem_addr, mem_we); end
        tick();
        mem_ack = 1'b0;
        #1;
        vectors++; if (if_ready !== 1'b1 || d_ready !== 1'b0 || if_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL rmid_done: ifr %b dr %b rdata %h exp 1 0 0badf00d", if_ready, d_ready, if_rdata); end
    endtask

    task automatic test_addr_hold();
        apply_reset();
        if_req = 1'b1; if_addr = 32'h400;
        tick();
        if_addr = 32'h500;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin mem_ack = 1'b1; mem_rdata = 32'h0000_0400; end
            #1;
            vectors++; if (mem_addr !== 32'h400 || mem_req !== 1'b1) begin errors++; $display("FAIL hold_c%0d: addr %h req %b exp 400 1", c, mem_addr, mem_req); end
            tick();
        end
        mem_ack = 1'b0;
        #1;
        vectors++; if (if_ready !== 1'b1 || if_rdata !== 32'h0000_0400) begin errors++; $display("FAIL hold_done: ready %b rdata %h exp 1 00000400", if_ready, if_rdata); end
        if_req = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        exp_d_rdata = '0;
        test_reset();
        test_fetch();
        test_store();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_addr_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer that shares one single-ported, variable-latency memory between instruction fetch (IF stage) and data access (MEM stage) of the pipelined MIPS core. It serializes requests, holds memory-side signals stable until the memory acknowledges, and returns read data with a one-cycle ready pulse. It also aborts stuck transactions with a watchdog, and drives a pipeline stall alongside the hazard/forwarding logic.

## Interface
- TIMEOUT, 255: maximum cycles `mem_req` is held without `mem_ack` before abort; 0 disables the watchdog; counter width is $clog2(TIMEOUT+1).
- ERR_DATA, 32'hDEADBEEF: value loaded into the requester's rdata on a timeout abort.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- if_req  in  1  fetch request, held high until `if_ready`.
- if_addr  in  32  fetch byte address.
- if_rdata  out  32  fetched instruction, registered.
- if_ready  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request, held high until `d_ready`.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data, registered.
- d_ready  out  1  one-cycle completion pulse for data.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  memory write enable, registered.
- mem_addr  out  32  memory address, registered.
- mem_wdata  out  32  memory write data, registered.
- mem_rdata  in  32  memory read data, valid when `mem_ack`=1.
- mem_ack  in  1  memory completion, sampled on the rising edge.
- bus_err  out  1  one-cycle pulse coincident with the ready pulse of a timed-out transaction.
- stall  out  1  combinational: (if_req & ~if_ready) | (d_req & ~d_ready).

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D. Register `last_grant` (0 = fetch, 1 = data).
- IDLE: eligible requests are `if_req & ~if_ready` and `d_req & ~d_ready`, so a requester is masked in its own ready cycle.
  - If only one request is eligible, grant it.
  - If both are eligible, grant data unless `last_grant`=1; in that case grant fetch, so grants alternate under contention.
- On grant: latch addr, we (0 for fetch), and wdata (fetch: 0) into the mem_* registers. Set `mem_req`=1, update `last_grant`, clear the watchdog counter, and go to BUSY_I or BUSY_D.
- BUSY_x: mem_* outputs are held constant. Requester inputs are ignored, so changes after grant have no effect.
  - `mem_ack`=1: capture `mem_rdata` into x_rdata (stores leave `d_rdata` unchanged), pulse x_ready, clear `mem_req`, go to IDLE.
  - Otherwise the counter increments. When it reaches TIMEOUT (and TIMEOUT≠0): load x_rdata = ERR_DATA (stores leave it unchanged), pulse x_ready and `bus_err`, clear `mem_req`, go to IDLE.
  - `mem_ack` takes precedence over timeout in the same cycle.
- `mem_ack` in IDLE is ignored.
- Reset values: state IDLE, `last_grant`=1 (first contended grant goes to fetch), `mem_req`/`mem_we`=0, `mem_addr`/`mem_wdata`=0, `if_rdata`/`d_rdata`=0, `if_ready`/`d_ready`/`bus_err`=0, counter 0.
- Reset mid-transaction abandons it: no ready pulse, and `mem_req` drops asynchronously. The memory must tolerate abandonment.

## Timing
- Request high in cycle 0 (IDLE) → `mem_req`=1 in cycle 1.
- Ack in cycle k (k≥1) → ready pulse and rdata valid in cycle k+1; state IDLE in cycle k+1.
- Minimum latency is 2 cycles (ack in cycle 1). Peak throughput is one transaction per 2 cycles.
- A new grant can issue in the ready cycle for the other requester only (the same requester is masked).
- Timeout: `mem_req` stays high for exactly TIMEOUT cycles, with the ready and `bus_err` pulse in the following cycle.
- `stall` follows inputs combinationally, with no extra latency; it is 0 in the ready cycle of a requester that has no other pending request.

## Test plan
- Fetch only, addr 0x100, mem acks in cycle 1 with 0x2002_0005 → `mem_req` high cycle 1, `if_ready`=1 and `if_rdata`=0x2002_0005 in cycle 2, `stall` high cycles 0–1.
- Store d_addr 0x40, wdata 0xCAFE_F00D, ack after 3 wait cycles → `mem_we`=1 and addr/wdata stable for 4 cycles, then `d_ready` pulse; `d_rdata` unchanged.
- Both requests held continuously from reset, ack every cycle → grants alternate fetch, data, fetch, data; neither requester waits more than one foreign transaction.
- TIMEOUT=4, load with no ack → `mem_req` high 4 cycles, then `d_ready`=`bus_err`=1 with `d_rdata`=0xDEADBEEF; a following fetch is served normally.
- Reset asserted during BUSY_D → `mem_req` drops immediately, no `d_ready`; after release with both requests pending, fetch is granted first.
- Change `if_addr` while in BUSY_I → `mem_addr` remains the latched value until ack.
